// File: rtl/bench_seq_core.sv
// Registered benchmark logic function behind a valid pipeline, with a MISR
// signature compactor that folds a programmable number of output vectors.
module bench_seq_core #(
    parameter int unsigned      IN_W  = 157,
    parameter int unsigned      OUT_W = 64,
    parameter int unsigned      PIPE  = 2,
    parameter int unsigned      SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             mode,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             sig_start,
    input  logic [15:0]      sig_len,
    output logic             sig_busy,
    output logic             sig_done,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned NSL = (OUT_W + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [15:0]         cnt;
    logic [OUT_W-1:0]    f_val;
    logic [OUT_W-1:0]    pipe_data [PIPE];
    logic [PIPE-1:0]     pipe_vld;
    logic [NSL*SIG_W-1:0] padded;
    logic [SIG_W-1:0]    fold;
    logic [SIG_W-1:0]    misr_next;

    always_comb begin
        f_val = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (i == 0)
                f_val[i] = in_data[0] & in_data[1];
            else if (i == 1)
                f_val[i] = in_data[0] | in_data[1];
            else if (!mode)
                f_val[i] = ~in_data[i % IN_W];
            else
                f_val[i] = in_data[i % IN_W] ^ in_data[(i + 1) % IN_W];
        end
    end

    // Data registers load only on a valid slot so bubbles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int unsigned k = 0; k < PIPE; k++)
                pipe_data[k] <= '0;
        end else begin
            pipe_vld[0] <= in_valid;
            if (in_valid)
                pipe_data[0] <= f_val;
            for (int unsigned k = 1; k < PIPE; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1])
                    pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    assign out_valid = pipe_vld[PIPE-1];
    assign out_data  = pipe_data[PIPE-1];

    // Top slice is zero-padded when OUT_W is not a multiple of SIG_W.
    always_comb begin
        padded            = '0;
        padded[OUT_W-1:0] = out_data;
        fold              = '0;
        for (int unsigned s = 0; s < NSL; s++)
            fold = fold ^ padded[s*SIG_W +: SIG_W];
        misr_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ fold;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sig_start) state_nx = (sig_len == 16'd0) ? DONE : RUN;
            RUN:     if (out_valid && cnt == 16'd1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            signature <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sig_start) begin
                        cnt       <= sig_len;
                        signature <= '1;
                    end
                end
                RUN: begin
                    if (out_valid) begin
                        signature <= misr_next;
                        cnt       <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sig_busy = (state == RUN);
    assign sig_done = (state == DONE);

endmodule
